vga_image_reader: RTL and testbench

- Display-side reader of the data memory's VGA read port. Drives `vgaAdress` and consumes the asynchronous `ImageData` byte.
- Generates 640x480@60 timing from the 50 MHz system clock, using an internal divide-by-2 pixel tick.
- Maps an 8-bit grayscale image stored at `BASE_ADDR` (row-major, one byte per pixel) to 3-3-2 RGB.
- The image is integer-upscaled and placed at the top-left of the screen. The rest of the screen is black.

---
 rtl/vga_image_reader_if.sv | 13 +
 rtl/vga_image_reader.sv | 134 +++++++++++++
 tb/tb_vga_image_reader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_image_reader_if.sv
// vga_image_reader_if
//   Read port between the VGA image reader and data memory.
//   vgaAdress : byte address driven by the reader (32 bits).
//   ImageData : pixel byte returned by memory, a combinational function of
//               vgaAdress (8 bits).
//   Modports: master = reader side, slave = memory side.
interface vga_image_reader_if;
  logic [31:0] vgaAdress;
  logic [7:0]  ImageData;

  modport master (output vgaAdress, input  ImageData);
  modport slave  (input  vgaAdress, output ImageData);
endinterface

// File: rtl/vga_image_reader.sv
// vga_image_reader
//   Display-side reader of the data memory's VGA port. Generates 640x480@60
//   timing from a 50 MHz clock via an internal divide-by-2 pixel tick, fetches
//   an 8-bit grayscale image (row-major, BASE_ADDR, IMG_W x IMG_H), upscales it
//   by 2^SCALE_SHIFT, places it top-left and outputs 3-3-2 RGB. Everything
//   outside the image is black.
// Ports:
//   clk         system clock, 50 MHz
//   rst         synchronous active-high reset
//   en          display enable (0 = black pixels, timing keeps running)
//   mem         memory read port (vgaAdress out, ImageData in)
//   hsync/vsync active-low syncs
//   red/green/blue  colour outputs (3/3/2 bits)
//   frame_start one-clk pulse when pixel (0,0) enters the pipeline
module vga_image_reader #(
  parameter logic [31:0] BASE_ADDR   = '0,
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 64,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  vga_image_reader_if.master         mem,
  output logic                       hsync,
  output logic                       vsync,
  output logic [2:0]                 red,
  output logic [2:0]                 green,
  output logic [1:0]                 blue,
  output logic                       frame_start
);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_LAST       = 10'd799;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_LAST       = 10'd524;

  // Pixel-tick phase: pix_tick is high on the first clk after reset release
  // and every other clk thereafter.
  logic       phase;
  logic       pix_tick;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  // Stage-1 registers (travel alongside vgaAdress for one tick).
  logic       hs1;
  logic       vs1;
  logic       px1;

  // Combinational decode of the current counter position.
  logic [9:0]  col;
  logic [9:0]  row;
  logic        in_img;
  logic        visible;
  logic        h_sync_act;
  logic        v_sync_act;
  logic [31:0] img_offset;

  // Only the top three bits of the pixel byte reach the 3-3-2 outputs.
  logic        unused_image_bits;

  assign pix_tick          = ~phase;
  assign unused_image_bits = ^mem.ImageData[4:0];

  always_comb begin
    col        = h_cnt >> SCALE_SHIFT;
    row        = v_cnt >> SCALE_SHIFT;
    in_img     = (32'(col) < IMG_W) && (32'(row) < IMG_H);
    visible    = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    h_sync_act = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    v_sync_act = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    img_offset = '0;
    if (in_img) begin
      img_offset = 32'(row) * IMG_W + 32'(col);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      mem.vgaAdress <= BASE_ADDR;
      hs1           <= 1'b1;
      vs1           <= 1'b1;
      px1           <= 1'b0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      frame_start   <= 1'b0;
    end else begin
      phase       <= ~phase;
      // Self-clears on the following (non-tick) clk, giving a one-clk pulse.
      frame_start <= pix_tick && (h_cnt == '0) && (v_cnt == '0);

      if (pix_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end

        // Stage 1: present the address and carry sync/valid alongside it.
        mem.vgaAdress <= BASE_ADDR + img_offset;
        hs1           <= ~h_sync_act;
        vs1           <= ~v_sync_act;
        px1           <= visible && in_img && en;

        // Stage 2: memory data for the stage-1 address is valid now.
        hsync <= hs1;
        vsync <= vs1;
        if (px1) begin
          red   <= mem.ImageData[7:5];
          green <= mem.ImageData[7:5];
          blue  <= mem.ImageData[7:6];
        end else begin
          red   <= '0;
          green <= '0;
          blue  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_image_reader.sv
module tb_vga_image_reader;

  localparam int BASE = 256;
  localparam int W    = 64;
  localparam int H    = 2;
  localparam int SC   = 4;
  localparam int FRAME_PIX = 800 * 525;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       hsync, vsync, frame_start;
  logic [2:0] red, green;
  logic [1:0] blue;

  logic [7:0] img_mem [0:4095];

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock edges since reset release, and en as sampled per consumed pixel.
  int   k = 0;
  logic en_at [0:7];

  vga_image_reader_if mem_if ();

  assign mem_if.ImageData = img_mem[mem_if.vgaAdress[11:0]];

  vga_image_reader #(
    .BASE_ADDR   (32'h0000_0100),
    .IMG_W       (64),
    .IMG_H       (2),
    .SCALE_SHIFT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mem         (mem_if.master),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if ((k + 1) % 2 == 1) en_at[(((k + 2) >> 1) - 1) % 8] <= en;
    end
  end

  // ---------------- reference model (pixel-index based) ----------------
  // After edge k, stage 1 holds pixel q = ceil(k/2)-1, the pins show q-1.
  function automatic int pix_out(int kk);
    return ((kk + 1) >> 1) - 2;
  endfunction

  function automatic int pix_addr(int kk);
    return ((kk + 1) >> 1) - 1;
  endfunction

  function automatic logic exp_hsync(int p);
    int h;
    if (p < 0) return 1'b1;
    h = p % 800;
    return !(h >= 656 && h <= 751);
  endfunction

  function automatic logic exp_vsync(int p);
    int v;
    if (p < 0) return 1'b1;
    v = (p / 800) % 525;
    return !(v >= 490 && v <= 491);
  endfunction

  function automatic logic in_image(int p);
    int h, v;
    h = p % 800;
    v = (p / 800) % 525;
    return (h / SC < W) && (v / SC < H);
  endfunction

  function automatic logic [31:0] exp_addr(int q);
    int h, v;
    if (q < 0 || !in_image(q)) return 32'(BASE);
    h = q % 800;
    v = (q / 800) % 525;
    return 32'(BASE + (v / SC) * W + h / SC);
  endfunction

  function automatic logic [7:0] exp_rgb(int p, logic en_s);
    int h, v;
    logic [7:0] b;
    if (p < 0 || !en_s) return 8'h00;
    h = p % 800;
    v = (p / 800) % 525;
    if (!(h < 640 && v < 480 && in_image(p))) return 8'h00;
    b = img_mem[BASE + (v / SC) * W + h / SC];
    return {b[7:5], b[7:5], b[7:6]};
  endfunction

  function automatic logic exp_fs(int kk);
    int q;
    q = pix_addr(kk);
    return (kk % 2 == 1) && (q >= 0) && (q % FRAME_PIX == 0);
  endfunction

  function automatic logic [7:0] pix_en_rgb(int kk);
    int p;
    p = pix_out(kk);
    if (p < 0) return 8'h00;
    return exp_rgb(p, en_at[p % 8]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lf;
    lf = 0;
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({hsync, vsync, red, green, blue, frame_start} !== {2'b11, 9'd0}) begin
        tests_failed++;
        $display("FAIL reset_outputs: got hs=%b vs=%b rgb=%h fs=%b, want hs=1 vs=1 rgb=00 fs=0",
                 hsync, vsync, {red, green, blue}, frame_start);
      end
      tests_run++;
      if (mem_if.vgaAdress !== 32'(BASE)) begin
        tests_failed++;
        $display("FAIL reset_addr: got %h want %h", mem_if.vgaAdress, BASE);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8 && lf < 4; i++) begin
      step();
      tests_run++;
      if (frame_start !== exp_fs(k)) begin
        tests_failed++; lf++;
        $display("FAIL first_frame_start: k=%0d got %b want %b", k, frame_start, exp_fs(k));
      end
    end
  endtask

  task automatic test_line_timing();
    int   lf, low_run, last_fall;
    logic prev_hs;
    lf = 0; low_run = 0; last_fall = -1; prev_hs = hsync;
    for (int i = 0; i < 3 * 1600 && lf < 4; i++) begin
      step();
      tests_run++;
      if ({hsync, vsync} !== {exp_hsync(pix_out(k)), exp_vsync(pix_out(k))}) begin
        tests_failed++; lf++;
        $display("FAIL sync_level: k=%0d got hs=%b vs=%b want hs=%b vs=%b", k, hsync, vsync,
                 exp_hsync(pix_out(k)), exp_vsync(pix_out(k)));
      end
      tests_run++;
      if (mem_if.vgaAdress !== exp_addr(pix_addr(k))) begin
        tests_failed++; lf++;
        $display("FAIL address: k=%0d got %0d want %0d", k, mem_if.vgaAdress, exp_addr(pix_addr(k)));
      end
      tests_run++;
      if (frame_start !== exp_fs(k)) begin
        tests_failed++; lf++;
        $display("FAIL frame_start: k=%0d got %b want %b", k, frame_start, exp_fs(k));
      end
      if (hsync === 1'b0) low_run++;
      if (prev_hs === 1'b1 && hsync === 1'b0) begin
        if (last_fall >= 0) begin
          tests_run++;
          if (k - last_fall !== 1600) begin
            tests_failed++; lf++;
            $display("FAIL line_period: got %0d clk want 1600", k - last_fall);
          end
        end
        last_fall = k;
      end
      if (prev_hs === 1'b0 && hsync === 1'b1) begin
        tests_run++;
        if (low_run !== 192) begin
          tests_failed++; lf++;
          $display("FAIL hsync_width: got %0d clk want 192", low_run);
        end
        low_run = 0;
      end
      prev_hs = hsync;
    end
  endtask

  task automatic test_image_pixels();
    int lf;
    lf = 0;
    for (int i = 0; i < 4096; i++) img_mem[i] = 8'($urandom);
    rst = 1'b1; en = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10 * 1600 && lf < 4; i++) begin
      step();
      tests_run++;
      if ({red, green, blue} !== pix_en_rgb(k)) begin
        tests_failed++; lf++;
        $display("FAIL pixel_colour: h=%0d v=%0d got %h want %h", pix_out(k) % 800,
                 pix_out(k) / 800, {red, green, blue}, pix_en_rgb(k));
      end
      tests_run++;
      if (mem_if.vgaAdress !== exp_addr(pix_addr(k))) begin
        tests_failed++; lf++;
        $display("FAIL pixel_address: k=%0d got %0d want %0d", k, mem_if.vgaAdress, exp_addr(pix_addr(k)));
      end
    end
  endtask

  task automatic test_enable();
    int lf;
    lf = 0;
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9 * 1600 && lf < 4; i++) begin
      step();
      tests_run++;
      if ({red, green, blue, hsync} !== {8'h00, exp_hsync(pix_out(k))}) begin
        tests_failed++; lf++;
        $display("FAIL en_off_black: k=%0d got rgb=%h hs=%b want rgb=00 hs=%b", k,
                 {red, green, blue}, hsync, exp_hsync(pix_out(k)));
      end
    end
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5 * 1600 && lf < 4; i++) begin
      if (i >= 2 * 1600 && $urandom_range(0, 99) < 3) en = ~en;
      step();
      tests_run++;
      if ({red, green, blue} !== pix_en_rgb(k)) begin
        tests_failed++; lf++;
        $display("FAIL en_toggle_colour: h=%0d v=%0d got %h want %h", pix_out(k) % 800,
                 pix_out(k) / 800, {red, green, blue}, pix_en_rgb(k));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_midframe_reset();
    int lf;
    lf = 0;
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0;
    // run until stage 1 has consumed h=300, v=2
    for (int i = 0; i < 2 * 1901 - 1 && lf < 4; i++) begin
      step();
      tests_run++;
      if ({hsync, red, green, blue} !== {exp_hsync(pix_out(k)), pix_en_rgb(k)}) begin
        tests_failed++; lf++;
        $display("FAIL pre_reset_run: k=%0d got hs=%b rgb=%h want hs=%b rgb=%h", k, hsync,
                 {red, green, blue}, exp_hsync(pix_out(k)), pix_en_rgb(k));
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if ({hsync, vsync, red, green, blue, frame_start} !== {2'b11, 9'd0}
        || mem_if.vgaAdress !== 32'(BASE)) begin
      tests_failed++;
      $display("FAIL midframe_reset_clk: got hs=%b vs=%b rgb=%h fs=%b addr=%0d want hs=1 vs=1 rgb=00 fs=0 addr=%0d",
               hsync, vsync, {red, green, blue}, frame_start, mem_if.vgaAdress, BASE);
    end
    for (int i = 0; i < 1700 && lf < 4; i++) begin
      step();
      tests_run++;
      if ({frame_start, hsync, red, green, blue} !==
          {exp_fs(k), exp_hsync(pix_out(k)), pix_en_rgb(k)}) begin
        tests_failed++; lf++;
        $display("FAIL post_reset_restart: k=%0d got fs=%b hs=%b rgb=%h want fs=%b hs=%b rgb=%h",
                 k, frame_start, hsync, {red, green, blue}, exp_fs(k),
                 exp_hsync(pix_out(k)), pix_en_rgb(k));
      end
      tests_run++;
      if (mem_if.vgaAdress !== exp_addr(pix_addr(k))) begin
        tests_failed++; lf++;
        $display("FAIL post_reset_addr: k=%0d got %0d want %0d", k, mem_if.vgaAdress, exp_addr(pix_addr(k)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) img_mem[i] = 8'hFF;
    for (int i = 0; i < 8; i++) en_at[i] = 1'b0;
    test_reset();
    test_line_timing();
    test_image_pixels();
    test_enable();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
